// File: rtl/digit_serial_multiplier.sv
// Digit-serial WIDTH x WIDTH unsigned multiplier feeding an external 4x4 combinational core.
// Optional zero-operand bypass: define DIGIT_SERIAL_ZERO_SKIP_EN.
module digit_serial_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic [3:0]           mult_a_out,
    output logic [3:0]           mult_b_out,
    input  logic [7:0]           mult_product_in,
    output logic [2*WIDTH-1:0]   product_out,
    output logic                 valid_out,
    input  logic                 ready_in
);

    localparam int D  = WIDTH / 4;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   pp_wide;
    logic [2*WIDTH-1:0]   pp_shifted;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [IW-1:0]        i_idx;
    logic [IW-1:0]        j_idx;
    logic [IW:0]          digit_sum;
    logic                 accept;
    logic                 last_pair;

`ifdef DIGIT_SERIAL_ZERO_SKIP_EN
    logic                 zero_op;
    assign zero_op = (a_in == {WIDTH{1'b0}}) || (b_in == {WIDTH{1'b0}});
`endif

    assign accept    = valid_in & ready_out;
    assign last_pair = (i_idx == LAST) && (j_idx == LAST);

    // Partial product weighted by digit position 4*(i+j), added to the running sum
    always_comb begin
        pp_wide       = {(2*WIDTH){1'b0}};
        pp_wide[7:0]  = mult_product_in;
        digit_sum     = {1'b0, i_idx} + {1'b0, j_idx};
        pp_shifted    = pp_wide << {digit_sum, 2'b00};
        acc_sum       = acc + pp_shifted;
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef DIGIT_SERIAL_ZERO_SKIP_EN
                    if (zero_op) begin
                        state_next = DONE;
                    end else begin
                        state_next = MUL;
                    end
`else
                    state_next = MUL;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            MUL: begin
                if (last_pair) begin
                    state_next = DONE;
                end else begin
                    state_next = MUL;
                end
            end
            DONE: begin
                if (valid_out & ready_in) begin
                    state_next = IDLE;
                end else begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs; digits reach the core only while multiplying
    always_comb begin
        ready_out  = 1'b0;
        mult_a_out = 4'd0;
        mult_b_out = 4'd0;
        case (state)
            IDLE: ready_out = 1'b1;
            MUL: begin
                mult_a_out = a_reg[{i_idx, 2'b00} +: 4];
                mult_b_out = b_reg[{j_idx, 2'b00} +: 4];
            end
            DONE:    ready_out = 1'b0;
            default: ready_out = 1'b0;
        endcase
    end

    // Operand latch, digit indices, accumulator and registered result
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            a_reg       <= {WIDTH{1'b0}};
            b_reg       <= {WIDTH{1'b0}};
            acc         <= {(2*WIDTH){1'b0}};
            i_idx       <= {IW{1'b0}};
            j_idx       <= {IW{1'b0}};
            product_out <= {(2*WIDTH){1'b0}};
            valid_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        acc   <= {(2*WIDTH){1'b0}};
                        i_idx <= {IW{1'b0}};
                        j_idx <= {IW{1'b0}};
`ifdef DIGIT_SERIAL_ZERO_SKIP_EN
                        if (zero_op) begin
                            product_out <= {(2*WIDTH){1'b0}};
                            valid_out   <= 1'b1;
                        end
`endif
                    end
                end
                MUL: begin
                    acc <= acc_sum;
                    if (last_pair) begin
                        product_out <= acc_sum;
                        valid_out   <= 1'b1;
                    end else if (j_idx == LAST) begin
                        j_idx <= {IW{1'b0}};
                        i_idx <= i_idx + IW'(1);
                    end else begin
                        j_idx <= j_idx + IW'(1);
                    end
                end
                DONE: begin
                    if (valid_out & ready_in) begin
                        valid_out <= 1'b0;
                    end
                end
                default: begin
                    valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_multiplier.sv
// Self-checking bench for digit_serial_multiplier with a behavioural 4x4 core attached.
// Expected products come from plain integer multiplication of the operands.
module tb_digit_serial_multiplier;

    localparam int WIDTH = 16;
    localparam int D     = WIDTH / 4;

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic [WIDTH-1:0]    a_in;
    logic [WIDTH-1:0]    b_in;
    logic                valid_in;
    logic                ready_out;
    logic [3:0]          mult_a_out;
    logic [3:0]          mult_b_out;
    logic [7:0]          mult_product_in;
    logic [2*WIDTH-1:0]  product_out;
    logic                valid_out;
    logic                ready_in;

    int checks = 0;
    int errors = 0;

    digit_serial_multiplier #(.WIDTH(WIDTH)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .a_in            (a_in),
        .b_in            (b_in),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .mult_a_out      (mult_a_out),
        .mult_b_out      (mult_b_out),
        .mult_product_in (mult_product_in),
        .product_out     (product_out),
        .valid_out       (valid_out),
        .ready_in        (ready_in)
    );

    // Reference 4x4 combinational core
    assign mult_product_in = 8'(mult_a_out) * 8'(mult_b_out);

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit skip_expected(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef DIGIT_SERIAL_ZERO_SKIP_EN
        return (a == 16'd0) || (b == 16'd0);
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge while idle; returns at the negedge after the accept edge
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        check("ready_before_accept", 64'(ready_out), 64'd1);
        a_in     = a;
        b_in     = b;
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
        a_in     = $urandom_range(0, 65535);
        b_in     = $urandom_range(0, 65535);
    endtask

    // Walks the digit pairs in i-outer/j-inner order and checks the result
    task automatic wait_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int          n = 0;
        bit          skip;
        logic [63:0] exp_prod;
        skip     = skip_expected(a, b);
        exp_prod = 64'(a) * 64'(b);
        while (valid_out !== 1'b1 && n < 200) begin
            if (!skip && n < D * D) begin
                check("mult_a_digit", 64'(mult_a_out), (64'(a) >> (4 * (n / D))) & 64'hF);
                check("mult_b_digit", 64'(mult_b_out), (64'(b) >> (4 * (n % D))) & 64'hF);
                check("ready_busy", 64'(ready_out), 64'd0);
            end
            @(negedge clk_in);
            n++;
        end
        check("valid_out_high", 64'(valid_out), 64'd1);
        check("latency_edges", 64'(n), skip ? 64'd0 : 64'(D * D));
        check("product", 64'(product_out), exp_prod);
        check("mult_a_idle_done", 64'(mult_a_out), 64'd0);
        check("ready_in_done", 64'(ready_out), 64'd0);
    endtask

    // With ready_in high, leave DONE and check the idle state that follows
    task automatic finish_op(input logic [63:0] exp_prod);
        ready_in = 1'b1;
        @(negedge clk_in);
        check("valid_drop", 64'(valid_out), 64'd0);
        check("ready_back", 64'(ready_out), 64'd1);
        check("product_hold", 64'(product_out), exp_prod);
    endtask

    initial begin
        rst_in   = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        a_in     = 16'd0;
        b_in     = 16'd0;
        repeat (2) @(negedge clk_in);
        check("rst_ready", 64'(ready_out), 64'd1);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_product", 64'(product_out), 64'd0);
        check("rst_mult_a", 64'(mult_a_out), 64'd0);
        check("rst_mult_b", 64'(mult_b_out), 64'd0);
        rst_in = 1'b1;
        @(negedge clk_in);

        // Directed: 0x1234 x 0x5678
        start_op(16'h1234, 16'h5678);
        wait_result(16'h1234, 16'h5678);
        check("p1234x5678", 64'(product_out), 64'h06260060);
        finish_op(64'h06260060);

        // Largest partial-product carries
        start_op(16'hFFFF, 16'hFFFF);
        wait_result(16'hFFFF, 16'hFFFF);
        check("pFFFFxFFFF", 64'(product_out), 64'hFFFE0001);
        finish_op(64'hFFFE0001);

        // Back-pressure in DONE with an ignored valid_in pulse
        ready_in = 1'b0;
        start_op(16'h00AB, 16'h0100);
        wait_result(16'h00AB, 16'h0100);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                a_in     = 16'h0007;
                b_in     = 16'h0009;
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk_in);
            check("hold_valid", 64'(valid_out), 64'd1);
            check("hold_product", 64'(product_out), 64'h0000AB00);
            check("hold_ready", 64'(ready_out), 64'd0);
        end
        valid_in = 1'b0;
        finish_op(64'h0000AB00);
        @(negedge clk_in);
        check("no_queued_op", 64'(ready_out), 64'd1);

        // Reset in the middle of MUL discards the operation
        start_op(16'h1234, 16'h5678);
        repeat (8) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        check("midrst_ready", 64'(ready_out), 64'd1);
        check("midrst_product", 64'(product_out), 64'd0);
        check("midrst_valid", 64'(valid_out), 64'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            check("midrst_no_valid", 64'(valid_out), 64'd0);
        end
        start_op(16'd3, 16'd5);
        wait_result(16'd3, 16'd5);
        check("p3x5", 64'(product_out), 64'h0000000F);
        finish_op(64'h0000000F);

        // Zero operand: bypass with the option, full pass without
        start_op(16'h0000, 16'hABCD);
        wait_result(16'h0000, 16'hABCD);
        finish_op(64'd0);

        // Random back-to-back traffic
        for (int t = 0; t < 1000; t++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = $urandom_range(0, 65535);
            rb = $urandom_range(0, 65535);
            if (t % 97 == 5) begin
                ra = 16'd0;
            end
            start_op(ra, rb);
            wait_result(ra, rb);
            finish_op(64'(ra) * 64'(rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
